// File: rtl/addsub_bcd_serial_ctrl.sv
// rtl/addsub_bcd_serial_ctrl.sv - bit-serial signed 4-bit add/sub with sign-magnitude BCD result
module addsub_bcd_serial_ctrl #(
    parameter bit CLR_ON_ACCEPT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_MAG  = 3'd2,
        S_ADJ  = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] a1_q, a1_d;
    logic [4:0] b1_q, b1_d;
    logic [4:0] m_q, m_d;
    logic [4:0] mag_q, mag_d;
    logic       carry_q, carry_d;
    logic       s_q, s_d;
    logic [2:0] idx_q, idx_d;
    logic [8:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;

    logic       fa_x;
    logic       fa_y;
    logic       fa_sum;
    logic       fa_cout;
    logic       mag_x;
    logic       bcd_fix;
    logic [4:0] mag_adj;

    // The single shared full-adder cell; its inputs are steered per state.
    always_comb begin
        fa_x    = a1_q[idx_q];
        fa_y    = b1_q[idx_q];
        fa_sum  = fa_x ^ fa_y ^ carry_q;
        fa_cout = (fa_x & fa_y) | (fa_x & carry_q) | (fa_y & carry_q);
        mag_x   = m_q[idx_q] ^ s_q;
        bcd_fix = mag_q[4] | (mag_q[3] & (mag_q[2] | mag_q[1]));
        mag_adj = bcd_fix ? (mag_q + 5'd6) : mag_q;
    end

    always_comb begin
        state_d     = state_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        m_d         = m_q;
        mag_d       = mag_q;
        carry_d     = carry_q;
        s_d         = s_q;
        idx_d       = idx_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a1_d    = {a[3], a};
                    b1_d    = {5{sub}} ^ {b[3], b};
                    carry_d = sub;
                    idx_d   = 3'd0;
                    m_d     = 5'd0;
                    mag_d   = 5'd0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                m_d[idx_q] = fa_sum;
                carry_d    = fa_cout;
                if (idx_q == 3'd4) begin
                    // Final carry is dropped: the 5-bit sum wraps, and its MSB is the sign.
                    s_d     = fa_sum;
                    carry_d = fa_sum;
                    idx_d   = 3'd0;
                    state_d = S_MAG;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_MAG: begin
                // Conditional two's-complement negate: invert with s, add s as initial carry.
                mag_d[idx_q] = mag_x ^ carry_q;
                carry_d      = mag_x & carry_q;
                if (idx_q == 3'd3) begin
                    mag_d[4] = mag_x & carry_q;
                    idx_d    = 3'd0;
                    state_d  = S_ADJ;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_ADJ: begin
                out_d       = {s_q, 3'b000, mag_adj};
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if (CLR_ON_ACCEPT) begin
                        out_d = 9'h000;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a1_q        <= 5'd0;
            b1_q        <= 5'd0;
            m_q         <= 5'd0;
            mag_q       <= 5'd0;
            carry_q     <= 1'b0;
            s_q         <= 1'b0;
            idx_q       <= 3'd0;
            out_q       <= 9'h000;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            m_q         <= m_d;
            mag_q       <= mag_d;
            carry_q     <= carry_d;
            s_q         <= s_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out       = out_q;

endmodule

// File: tb/tb_addsub_bcd_serial_ctrl.sv
// tb/tb_addsub_bcd_serial_ctrl.sv - self-checking bench for addsub_bcd_serial_ctrl
module tb_addsub_bcd_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       sub = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;

    logic       in_ready0, out_valid0, busy0;
    logic [8:0] out0;
    logic       in_ready1, out_valid1, busy1;
    logic [8:0] out1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    addsub_bcd_serial_ctrl #(.CLR_ON_ACCEPT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid0), .out_ready(out_ready),
        .out(out0), .busy(busy0)
    );

    addsub_bcd_serial_ctrl #(.CLR_ON_ACCEPT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid1), .out_ready(out_ready),
        .out(out1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Signed arithmetic on integers, then decimal split of the magnitude.
    function automatic logic [8:0] ref_out(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts);
        int ia, ib, r, m;
        logic [8:0] o;
        ia = int'($signed(ta));
        ib = int'($signed(tb_v));
        r  = ts ? (ia - ib) : (ia + ib);
        m  = (r < 0) ? -r : r;
        o      = '0;
        o[8]   = (r < 0);
        o[4]   = (m >= 10);
        o[3:0] = 4'(m % 10);
        return o;
    endfunction

    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts,
                         input logic [8:0] exp, input int hold, input bit pulse);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
        chk("in_ready_idle", in_ready0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid0 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, 10);
        chk("out", out0, exp);
        chk("out_clr", out1, exp);
        chk("valid_clr", out_valid1, 1);
        chk("busy_hold", busy0, 1);
        chk("in_ready_hold", in_ready0, 0);
        for (int i = 0; i < hold; i++) begin
            if (pulse) begin
                in_valid = 1'($urandom);
                a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            chk("hold_out", out0, exp);
            chk("hold_valid", out_valid0, 1);
            chk("hold_in_ready", in_ready0, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", out_valid0, 0);
        chk("retain", out0, exp);
        chk("clear", out1, 0);
        chk("idle_busy", busy0, 0);
        chk("idle_ready", in_ready0, 1);
    endtask

    initial begin : main
        logic [8:0] expq[$];
        logic [3:0] ra, rb;
        logic       rs;
        int p, nres, last_c, lowrun, seen;
        bit prev_busy;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_out", out0, 0);
        rst_n = 1'b1;

        do_op(4'd3, 4'd4, 1'b0, 9'h007, 0, 0);
        do_op(4'd7, 4'h8, 1'b1, 9'h015, 0, 0);
        do_op(4'h8, 4'h8, 1'b0, 9'h116, 0, 0);
        do_op(4'd2, 4'd5, 1'b1, 9'h103, 0, 0);
        do_op(4'd5, 4'd5, 1'b1, 9'h000, 20, 1);

        // Back-to-back: in_valid held, out_ready held.
        p = 0; nres = 0; last_c = 0; lowrun = 0; prev_busy = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (out_valid0) begin
                if (expq.size() == 0) chk("b2b_extra", 1, 0);
                else chk("b2b_out", out0, expq.pop_front());
                if (nres > 0) chk("b2b_period", c - last_c, 12);
                last_c = c;
                nres++;
            end
            if (busy0) begin
                if (!prev_busy && nres > 0) chk("b2b_gap", lowrun, 1);
                lowrun = 0;
            end else begin
                lowrun++;
            end
            prev_busy = busy0;
            if (in_ready0) begin
                if (p < 4) begin
                    a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom);
                    in_valid = 1'b1;
                    expq.push_back(ref_out(a, b, sub));
                    p++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_count", nres, 4);

        // Reset during MAG.
        @(negedge clk);
        a = 4'd3; b = 4'd2; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready0, 1);
        chk("mid_rst_out_valid", out_valid0, 0);
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_out", out0, 0);
        chk("mid_rst_out_clr", out1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid0 || busy0) seen++;
        end
        chk("no_stale_result", seen, 0);
        do_op(4'd1, 4'd1, 1'b0, 9'h002, 0, 0);

        // Random operands with random consumer stalls.
        for (int i = 0; i < 30; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
            do_op(ra, rb, rs, ref_out(ra, rb, rs), int'($urandom_range(0, 4)), 1'($urandom));
        end

        // Exhaustive sweep of every {sub, b, a}.
        for (int i = 0; i < 512; i++) begin
            ra = i[3:0]; rb = i[7:4]; rs = i[8];
            do_op(ra, rb, rs, ref_out(ra, rb, rs), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_bcd_serial_ctrl.md
Name: addsub_bcd_serial_ctrl

Overview:
- Multi-cycle controller that computes the same signed 4-bit add/subtract with sign-magnitude BCD result as the existing combinational adder_substractor datapath.
- Uses one time-shared full-adder cell plus an FSM instead of the ten-cell ripple chains.
- Operands enter through a valid/ready handshake; the result leaves through a valid/ready handshake.
- Sits between the operand-entry front end and the display/result register stage.

Parameters:
- CLR_ON_ACCEPT, 0, 1 = clear out to 9'h000 on the cycle after the output handshake; 0 = out retains the last result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  controller can accept operands
- a  input  4  signed two's-complement operand A
- b  input  4  signed two's-complement operand B
- sub  input  1  1 = A-B, 0 = A+B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  9  out[8] sign, out[7:5] zero, out[4] tens digit (0/1), out[3:0] ones digit BCD
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0, out=9'h000. All internal registers (operand, partial sum, carry, bit index) are cleared.
- States: IDLE -> ADD -> MAG -> ADJ -> HOLD -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture a1={a[3],a}, b1={5{sub}}^{b[3],b}, carry=sub, idx=0; go to ADD.
- ADD (5 cycles, idx 0..4):
  - One full-adder evaluation per cycle: m[idx]=a1[idx]^b1[idx]^carry; carry=majority(a1[idx],b1[idx],carry).
  - After idx=4: set s=m[4], carry=m[4], idx=0; go to MAG.
  - Final ADD carry is discarded (5-bit wrap).
- MAG (4 cycles, idx 0..3):
  - mag[idx]=(m[idx]^s)^carry; carry=(m[idx]^s)&carry.
  - After idx=3: mag[4]=carry; go to ADJ.
- ADJ (1 cycle):
  - If mag[4] | (mag[3]&(mag[2]|mag[1])), then mag=mag+5'd6, truncated to 5 bits.
  - Load out={s,3'b000,mag[4:0]} and set out_valid=1; go to HOLD.
- HOLD:
  - out and out_valid stay stable while out_ready=0.
  - On out_ready=1: out_valid=0 next cycle and go to IDLE. If CLR_ON_ACCEPT=1, out is also cleared to 9'h000.
  - in_ready=0 throughout HOLD, so there is no same-cycle re-accept.
- Latency: out_valid rises exactly 10 clock edges after the accepting edge.
- Throughput: minimum 12 cycles per operation, with out_ready held at 1.
- in_valid and operand changes outside IDLE are ignored. Operands are sampled only at the accepting edge.
- Zero result: s=0 always, out=9'h000. No negative zero.
- Result range: -16..+15. Magnitude 16 encodes as out[4]=1, out[3:0]=4'h6.
- Reset asserted mid-operation: immediate return to the reset values above. The partial result is lost and out_valid is never asserted for it.
- out_ready while out_valid=0 is ignored.

Test Plan:
- a=3, b=4, sub=0 -> out=9'h007, with out_valid 10 edges after accept.
- a=7, b=-8 (4'h8), sub=1 -> +15, exercises the +6 correction -> out=9'h015.
- a=-8, b=-8, sub=0 -> -16 -> out=9'h116. Then a=2, b=5, sub=1 -> out=9'h103.
- a=5, b=5, sub=1 -> out=9'h000 (sign 0). Hold out_ready=0 for 20 cycles: out stable, out_valid high, in_ready low. Pulsing in_valid with new operands in this window has no effect.
- Back-to-back: in_valid held high and out_ready=1 continuously -> one result per 12 cycles, results in order, busy low exactly one cycle between operations.
- Assert rst_n=0 during MAG -> all outputs return to reset values asynchronously. After release, a=1, b=1, sub=0 -> out=9'h002.
- Exhaustive sweep: all 512 {a,b,sub} -> out equals the sign-magnitude BCD of the two's-complement result. Repeat with CLR_ON_ACCEPT=1: out=9'h000 after each handshake.
